// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, sequences ibus requests and feeds
// the F/D register through a 2-entry output buffer that absorbs downstream stalls.
package fetch_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic [31:0] raw_instr;
      logic [63:0] pc;
      logic        stall;
   } fetch_data_t;
endpackage

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   output ibus_req_t    ireq,
   input  ibus_resp_t   iresp,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [63:0]  redirect_pc,
   output fetch_data_t  dataF,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, BUSY, BUSY_DISCARD} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic [31:0] buf_instr_q [BUF_DEPTH];
   logic [63:0] buf_pc_q    [BUF_DEPTH];

   logic        pop, push, outstanding, issue_ok, wr_idx;
   logic [2:0]  occupancy;
   logic        unused_addr_ok;

   // Request holds its address until data_ok, so the address handshake is not needed.
   assign unused_addr_ok = iresp.addr_ok;

   assign outstanding = (state_q != IDLE);
   assign pop         = (count_q != 2'd0) && !stall;
   // A slot is reserved at issue, so occupancy counts the in-flight request too.
   assign occupancy   = {1'b0, count_q} - {2'b00, pop} + {2'b00, outstanding};
   assign issue_ok    = occupancy < 3'(BUF_DEPTH);
   assign wr_idx      = head_q ^ count_q[0];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      count_d    = count_q;
      head_d     = head_q;
      push       = 1'b0;

      if (pop) begin
         head_d  = ~head_q;
         count_d = count_q - 2'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (issue_ok && !redirect_valid) begin
               state_d    = BUSY;
               req_addr_d = pc_q;
            end
         end
         BUSY: begin
            if (iresp.data_ok) begin
               if (redirect_valid) begin
                  state_d = IDLE;
               end else begin
                  push = 1'b1;
                  pc_d = req_addr_q + 64'd4;
                  if (issue_ok) req_addr_d = req_addr_q + 64'd4;
                  else          state_d    = IDLE;
               end
            end else if (redirect_valid) begin
               state_d = BUSY_DISCARD;
            end
         end
         BUSY_DISCARD: begin
            if (iresp.data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (push) count_d = count_d + 2'd1;

      if (redirect_valid) begin
         count_d = '0;
         pc_d    = {redirect_pc[63:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= PC_RESET;
         req_addr_q <= '0;
         count_q    <= '0;
         head_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         count_q    <= count_d;
         head_q     <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_idx] <= iresp.data;
         buf_pc_q[wr_idx]    <= req_addr_q;
      end
   end

   always_comb begin
      dataF = '{raw_instr: '0, pc: '0, stall: 1'b1};
      if (count_q != 2'd0) begin
         dataF = '{raw_instr: buf_instr_q[head_q], pc: buf_pc_q[head_q], stall: 1'b0};
      end
   end

   assign ireq.valid = outstanding;
   assign ireq.addr  = req_addr_q;
   assign busy       = outstanding;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable ibus responder plus a queue-based
// scoreboard of the instruction stream, with directed scenarios and a random run.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   ibus_req_t   ireq;
   ibus_resp_t  iresp = '0;
   fetch_data_t dataF;
   logic        busy;

   int checks = 0;
   int passed = 0;

   int  age = 0;
   int  cur_lat = 1;
   int  lat_cfg = 1;
   bit  rnd_lat = 0;
   bit  rnd_aok = 0;
   bit  prev_dok = 0;
   bit  mon_en = 0;

   rec_t        exp_q[$];
   logic [63:0] model_pc = PC_RESET;
   int          epoch = 0;
   int          req_epoch = 0;
   logic [63:0] req_addr_m = '0;

   fetch_unit #(.PC_RESET(PC_RESET), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dataF(dataF), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   // Responder: age counts cycles the current request has been presented.
   always @(posedge clk) begin
      #2;
      if (reset) begin
         age = 0;
         prev_dok = 0;
         iresp = '0;
      end else begin
         if (!ireq.valid) age = 0;
         else if (age == 0 || prev_dok) begin
            age = 1;
            cur_lat = rnd_lat ? int'($urandom_range(1, 4)) : lat_cfg;
         end else age++;
         prev_dok = ireq.valid && (age >= cur_lat);
         iresp.data_ok = prev_dok;
         iresp.addr_ok = ireq.valid && (rnd_aok ? ($urandom_range(0, 1) == 1) : 1'b1);
         iresp.data = ireq.valid ? mem_word(ireq.addr) : $urandom;
      end
   end

   // Scoreboard: the expected buffer is a queue of accepted responses; a redirect
   // or reset bumps the epoch so any request issued before it is never emitted.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            if (dataF !== {32'h0, 64'h0, 1'b1})
               $display("FAIL dataF_empty got instr=%h pc=%h stall=%b, expected 0/0/1", dataF.raw_instr, dataF.pc, dataF.stall);
            else passed++;
         end else begin
            if (dataF !== {exp_q[0].instr, exp_q[0].pc, 1'b0})
               $display("FAIL dataF_head got instr=%h pc=%h stall=%b, expected instr=%h pc=%h stall=0", dataF.raw_instr, dataF.pc, dataF.stall, exp_q[0].instr, exp_q[0].pc);
            else passed++;
         end
         if (!stall && exp_q.size() > 0) void'(exp_q.pop_front());

         if (!reset && ireq.valid && age == 1) begin
            req_epoch  = epoch;
            req_addr_m = ireq.addr;
            checks++;
            if (ireq.addr !== model_pc)
               $display("FAIL req_addr got %h, expected %h", ireq.addr, model_pc);
            else passed++;
         end else if (!reset && ireq.valid && age > 1) begin
            checks++;
            if (ireq.addr !== req_addr_m)
               $display("FAIL req_hold got %h, expected %h", ireq.addr, req_addr_m);
            else passed++;
         end

         if (reset) begin
            exp_q.delete();
            model_pc = PC_RESET;
            epoch++;
         end else begin
            if (redirect_valid) begin
               exp_q.delete();
               epoch++;
               model_pc = {redirect_pc[63:2], 2'b00};
            end
            if (ireq.valid && iresp.data_ok && req_epoch == epoch) begin
               exp_q.push_back('{instr: iresp.data, pc: req_addr_m});
               model_pc = req_addr_m + 64'd4;
               checks++;
               if (exp_q.size() > 2)
                  $display("FAIL buffer_capacity got %0d entries, expected at most 2", exp_q.size());
               else passed++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish, got %0d/%0d", passed, checks);
      $fatal(1);
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      @(posedge clk); #1;
      mon_en = 1;
      @(negedge clk);
      checks++;
      if (dataF !== {32'h0, 64'h0, 1'b1})
         $display("FAIL reset_dataF got instr=%h pc=%h stall=%b, expected 0/0/1", dataF.raw_instr, dataF.pc, dataF.stall);
      else passed++;
      checks++;
      if (ireq.valid !== 1'b0) $display("FAIL reset_valid got %b, expected 0", ireq.valid); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b, expected 0", busy); else passed++;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_zero_latency();
      int n;
      logic [63:0] a;
      lat_cfg = 1; rnd_lat = 0; rnd_aok = 0;
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (!(ireq.valid && age == 1) && n < 20) begin @(negedge clk); n++; end
         checks++;
         if (n >= 20) $display("FAIL zl_start_timeout got none after %0d cycles, expected a request", n); else passed++;
         a = PC_RESET + 64'(4 * i);
         checks++;
         if (ireq.addr !== a) $display("FAIL zl_addr got %h, expected %h", ireq.addr, a); else passed++;
         @(negedge clk);
         checks++;
         if (dataF.pc !== a || dataF.stall !== 1'b0)
            $display("FAIL zl_dataF got pc=%h stall=%b, expected pc=%h stall=0", dataF.pc, dataF.stall, a);
         else passed++;
      end
   endtask

   task automatic test_slow();
      int n, k;
      logic [63:0] a;
      lat_cfg = 3; rnd_lat = 0; rnd_aok = 1;
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (!(ireq.valid && age == 1) && n < 20) begin @(negedge clk); n++; end
         a = PC_RESET + 64'(4 * i);
         checks++;
         if (ireq.addr !== a) $display("FAIL slow_addr got %h, expected %h", ireq.addr, a); else passed++;
         k = 1;
         while (!iresp.data_ok && k < 10) begin
            @(negedge clk);
            k++;
            checks++;
            if (ireq.valid !== 1'b1 || ireq.addr !== a)
               $display("FAIL slow_hold got valid=%b addr=%h, expected valid=1 addr=%h", ireq.valid, ireq.addr, a);
            else passed++;
         end
         checks++;
         if (k != 3) $display("FAIL slow_len got %0d cycles, expected 3", k); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      int n, got, accepted;
      logic [63:0] a;
      lat_cfg = 1; rnd_lat = 0; rnd_aok = 0;
      do_reset();
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && iresp.data_ok) && n < 20) begin @(negedge clk); n++; end
      accepted = 1;
      @(posedge clk); #1;
      stall = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ireq.valid && iresp.data_ok) accepted++;
         checks++;
         if (dataF.pc !== PC_RESET || dataF.stall !== 1'b0)
            $display("FAIL stall_hold got pc=%h stall=%b, expected pc=%h stall=0", dataF.pc, dataF.stall, PC_RESET);
         else passed++;
      end
      checks++;
      if (ireq.valid !== 1'b0) $display("FAIL stall_valid got %b, expected 0", ireq.valid); else passed++;
      checks++;
      if (accepted != 2) $display("FAIL stall_accepted got %0d, expected 2", accepted); else passed++;
      @(posedge clk); #1;
      stall = 1'b0;
      got = 0; n = 0;
      while (got < 3 && n < 30) begin
         @(negedge clk);
         n++;
         if (dataF.stall === 1'b0) begin
            a = PC_RESET + 64'(4 * got);
            checks++;
            if (dataF.pc !== a) $display("FAIL stall_order got %h, expected %h", dataF.pc, a); else passed++;
            got++;
         end
      end
      checks++;
      if (got != 3) $display("FAIL stall_records got %0d, expected 3", got); else passed++;
   endtask

   task automatic test_redirect();
      int n;
      bit seen;
      logic [63:0] a;
      lat_cfg = 3; rnd_lat = 0; rnd_aok = 1;
      do_reset();
      a = PC_RESET + 64'd4;
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && age == 1 && ireq.addr == a) && n < 30) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1002;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (iresp.data_ok) seen = 1;
         checks++;
         if (ireq.valid !== 1'b1 || ireq.addr !== a || dataF.stall !== 1'b1)
            $display("FAIL redir_hold got valid=%b addr=%h dstall=%b, expected 1/%h/1", ireq.valid, ireq.addr, dataF.stall, a);
         else passed++;
         @(posedge clk); #1;
         redirect_valid = 1'b0;
         #1;
      end
      checks++;
      if (!seen) $display("FAIL redir_dataok got none, expected data_ok within 10 cycles"); else passed++;
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && age == 1) && n < 20) begin
         checks++;
         if (dataF.stall !== 1'b1) $display("FAIL redir_gap got stall=%b, expected 1", dataF.stall); else passed++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (ireq.addr !== 64'h0000_0000_8000_1000)
         $display("FAIL redir_target got %h, expected 0000000080001000", ireq.addr);
      else passed++;
   endtask

   task automatic test_redirect_data_ok();
      int n;
      lat_cfg = 3; rnd_lat = 0; rnd_aok = 0;
      do_reset();
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && iresp.data_ok) && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      stall = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && age == 2) && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_2006;
      @(negedge clk);
      checks++;
      if (ireq.valid !== 1'b1 || ireq.addr !== PC_RESET + 64'd4 || dataF.stall !== 1'b0 || dataF.pc !== PC_RESET)
         $display("FAIL rdo_pre got valid=%b addr=%h dpc=%h dstall=%b, expected 1/%h/%h/0", ireq.valid, ireq.addr, dataF.pc, dataF.stall, PC_RESET + 64'd4, PC_RESET);
      else passed++;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dataF.stall !== 1'b1) $display("FAIL rdo_flush got stall=%b, expected 1", dataF.stall); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL rdo_idle got busy=%b, expected 0", busy); else passed++;
      n = 0;
      while (!(ireq.valid && age == 1) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (ireq.addr !== 64'h0000_0000_8000_2004)
         $display("FAIL rdo_target got %h, expected 0000000080002004", ireq.addr);
      else passed++;
      @(posedge clk); #1;
      stall = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      lat_cfg = 3; rnd_lat = 0; rnd_aok = 0;
      do_reset();
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && iresp.data_ok) && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      stall = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && age == 2) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (dataF.stall !== 1'b0 || busy !== 1'b1)
         $display("FAIL rmid_pre got dstall=%b busy=%b, expected 0/1", dataF.stall, busy);
      else passed++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (dataF !== {32'h0, 64'h0, 1'b1} || ireq.valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL rmid_post got dstall=%b dpc=%h valid=%b busy=%b, expected 1/0/0/0", dataF.stall, dataF.pc, ireq.valid, busy);
      else passed++;
      stall = 1'b0;
      n = 0;
      while (!(ireq.valid && age == 1) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (ireq.addr !== PC_RESET) $display("FAIL rmid_restart got %h, expected %h", ireq.addr, PC_RESET); else passed++;
   endtask

   task automatic test_wrap();
      int n;
      rnd_lat = 1; rnd_aok = 1;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(ireq.valid && age == 1) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (ireq.addr !== 64'hFFFF_FFFF_FFFF_FFFC)
         $display("FAIL wrap_first got %h, expected FFFFFFFFFFFFFFFC", ireq.addr);
      else passed++;
      @(negedge clk);
      n = 0;
      while (!(ireq.valid && age == 1) && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (ireq.addr !== 64'h0) $display("FAIL wrap_next got %h, expected 0000000000000000", ireq.addr); else passed++;
   endtask

   task automatic test_random();
      rnd_lat = 1; rnd_aok = 1;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         stall = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                   : {$urandom, $urandom};
         reset = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk); #1;
      reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_slow();
      test_stall();
      test_redirect();
      test_redirect_data_ok();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
